// File: rtl/packet_injector_pkg.sv
// Shared definitions for the packet injector: packet field layout,
// FSM state encoding, debounce default and a packet assembly helper.
package packet_injector_pkg;

  localparam int unsigned DATA_LSB    = 0;
  localparam int unsigned DATA_W      = 16;
  localparam int unsigned DEST_LSB    = 16;
  localparam int unsigned DEST_W      = 5;
  localparam int unsigned SEQ_LSB     = 32;
  localparam int unsigned PKT_W       = 38;
  localparam int unsigned SEQ_FIELD_W = PKT_W - SEQ_LSB;

  localparam int unsigned DEBOUNCE_DEFAULT = 2500000;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Assemble {seq, zero pad, dest, data}; unused bits are zero.
  function automatic logic [PKT_W-1:0] pack_packet(
    input logic [SEQ_FIELD_W-1:0] seq,
    input logic [DEST_W-1:0]      dest,
    input logic [DATA_W-1:0]      data
  );
    logic [PKT_W-1:0] p;
    p = '0;
    p[DATA_LSB +: DATA_W]      = data;
    p[DEST_LSB +: DEST_W]      = dest;
    p[SEQ_LSB +: SEQ_FIELD_W]  = seq;
    return p;
  endfunction

endpackage

// File: rtl/packet_injector_btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stable-level counter and a
// one-cycle pulse on each accepted release->press transition.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = packet_injector_pkg::DEBOUNCE_DEFAULT
) (
  input  logic CLK,
  input  logic RST,
  input  logic BTN,
  output logic PRESS
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // Synchronise, count while the input disagrees with the accepted level,
  // flip the level once it has disagreed long enough.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      PRESS <= 1'b0;
    end else begin
      sync1 <= BTN;
      sync2 <= sync1;
      PRESS <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= sync2;
        cnt   <= '0;
        PRESS <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/packet_injector.sv
// Operator packet composer: builds a token packet from switches and
// debounced buttons, then offers it to the pipeline over REQ/ACK.
module packet_injector
  import packet_injector_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned SEQ_W           = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [3:0]       SW,
  input  logic             BTN_NIB,
  input  logic             BTN_DEST,
  input  logic             BTN_SEND,
  input  logic             SEND_ACK,
  output logic             SEND_REQ,
  output logic [PKT_W-1:0] PACKET_OUT,
  output logic [DATA_W-1:0] DATA_VIEW,
  output logic             BUSY
);

  logic [3:0]        sw_s1;
  logic [3:0]        sw_s2;
  logic              nib_pulse;
  logic              dest_pulse;
  logic              send_pulse;
  logic [DEST_W-1:0] dest;
  logic [SEQ_W-1:0]  seq;
  state_t            state;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_nib (
    .CLK(CLK), .RST(RST), .BTN(BTN_NIB), .PRESS(nib_pulse)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dest (
    .CLK(CLK), .RST(RST), .BTN(BTN_DEST), .PRESS(dest_pulse)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_send (
    .CLK(CLK), .RST(RST), .BTN(BTN_SEND), .PRESS(send_pulse)
  );

  // Bring the slide switches into the clock domain.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= SW;
      sw_s2 <= sw_s1;
    end
  end

  // Compose / send FSM; DATA_VIEW is the data register itself.
  // A send pulse takes priority and snapshots pre-update data/dest,
  // discarding any nib/dest pulse in the same cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      DATA_VIEW  <= '0;
      dest       <= '0;
      seq        <= '0;
      PACKET_OUT <= '0;
      SEND_REQ   <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (send_pulse) begin
            PACKET_OUT <= pack_packet(SEQ_FIELD_W'(seq), dest, DATA_VIEW);
            SEND_REQ   <= 1'b1;
            BUSY       <= 1'b1;
            state      <= SEND;
          end else begin
            if (nib_pulse)  DATA_VIEW <= {DATA_VIEW[DATA_W-5:0], sw_s2};
            if (dest_pulse) dest      <= {1'b0, sw_s2};
          end
        end
        SEND: begin
          if (SEND_ACK && SEND_REQ) begin
            SEND_REQ <= 1'b0;
            BUSY     <= 1'b0;
            seq      <= seq + 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
